// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr
//   Single-grant arbiter with a registered, handshaked output. A winner is
//   picked from req, and it is held on out_idx until the consumer accepts it
//   with out_ready. The winner is chosen in one of two ways:
//     RR_MODE=0 : the highest set index of req wins.
//     RR_MODE=1 : round-robin. The search runs downward from ptr and wraps
//                 from 0 to N-1.
//
// Parameters
//   N        number of requesters (>= 2)
//   RR_MODE  0 = fixed priority, 1 = round-robin
//   W        index width, derived from N
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[N]      request vector, bit i = requester i
//   out_ready   consumer accepts the current grant
//   out_valid   a grant is held on out_idx
//   out_idx[W]  index of the granted requester
//   out_onehot  one-hot of out_idx, zero while out_valid=0
//   out_multi   more than one request was pending when the grant was captured
module priority_arbiter_rr #(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state, state_nxt;
    logic         load;
    logic         hs;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] idx_dec;
    logic [W-1:0] win;
    logic [N-1:0] req_m1;
    logic         multi;

    assign out_valid = (state == GRANT);
    assign hs        = out_valid & out_ready;

    // (out_idx - 1) mod N. This wraps at N, not 2^W, so a non-power-of-two N
    // never points past the last requester.
    assign idx_dec = (out_idx == '0) ? LAST : out_idx - W'(1);

    // A back-to-back capture must search from the pointer the handshake is
    // about to write, not from the stale one. In fixed mode ptr stays at N-1.
    // A downward search from N-1 is plain highest-index priority.
    assign ptr_eff = (RR_MODE != 0 && hs) ? idx_dec : ptr;

    // At least two bits are set exactly when clearing the lowest set bit
    // leaves something behind.
    assign req_m1 = req - N'(1);
    assign multi  = (req & req_m1) != '0;

    // Downward circular search starting at ptr_eff.
    always_comb begin
        logic found;
        int   pos;
        win   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr_eff) - k + N) % N;
            if (!found && req[pos]) begin
                win   = W'(pos);
                found = 1'b1;
            end
        end
    end

    // FSM next state and capture strobe.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    load      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    if (req != '0) load      = 1'b1;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx   <= '0;
            out_multi <= 1'b0;
        end else if (load) begin
            out_idx   <= win;
            out_multi <= multi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ptr <= LAST;
        else if (RR_MODE != 0 && hs) ptr <= idx_dec;
    end

    always_comb begin
        out_onehot = '0;
        if (out_valid) out_onehot[out_idx] = 1'b1;
    end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
module tb_priority_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdy;
    logic [3:0] req4;
    logic [4:0] req5;

    logic       fv, rv, qv;
    logic [1:0] fi, ri;
    logic [2:0] qi;
    logic [3:0] fo, ro;
    logic [4:0] qo;
    logic       fm, rm, qm;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state: 0 = fixed N=4, 1 = RR N=4, 2 = RR N=5.
    int mv[3], mi[3], mm[3], mp[3];

    always #5 clk = ~clk;

    priority_arbiter_rr #(.N(4), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(rdy),
        .out_valid(fv), .out_idx(fi), .out_onehot(fo), .out_multi(fm));

    priority_arbiter_rr #(.N(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(rdy),
        .out_valid(rv), .out_idx(ri), .out_onehot(ro), .out_multi(rm));

    priority_arbiter_rr #(.N(5), .RR_MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .out_ready(rdy),
        .out_valid(qv), .out_idx(qi), .out_onehot(qo), .out_multi(qm));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int n_of(int j);
        return (j == 2) ? 5 : 4;
    endfunction

    function automatic logic [7:0] req_of(int j);
        return (j == 2) ? {3'b0, req5} : {4'b0, req4};
    endfunction

    function automatic int hi_bit(logic [7:0] r, int n);
        for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    // Circular search: p, p-1, ..., 0, n-1, ..., p+1.
    function automatic int rr_pick(logic [7:0] r, int p, int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (p - k + n) % n;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            mv[j] = 0; mi[j] = 0; mm[j] = 0; mp[j] = n_of(j) - 1;
        end
    endtask

    task automatic model_update();
        for (int j = 0; j < 3; j++) begin
            int n, p;
            bit rr, hs;
            logic [7:0] r;
            n  = n_of(j);
            rr = (j != 0);
            hs = (mv[j] != 0) && rdy;
            r  = req_of(j);
            if (mv[j] == 0 || hs) begin
                p = mp[j];
                if (hs && rr) begin
                    p     = (mi[j] + n - 1) % n;
                    mp[j] = p;
                end
                if (r != 0) begin
                    mi[j] = rr ? rr_pick(r, p, n) : hi_bit(r, n);
                    mm[j] = ($countones(r) >= 2) ? 1 : 0;
                    mv[j] = 1;
                end else begin
                    mv[j] = 0;
                end
            end
        end
    endtask

    task automatic chk_inst(input string nm, input int j, input logic v,
                            input logic [7:0] idx, input logic [7:0] oh, input logic m);
        chk({nm, " valid"},  32'(v),   32'(mv[j]));
        chk({nm, " idx"},    32'(idx), 32'(mi[j]));
        chk({nm, " onehot"}, 32'(oh),  mv[j] != 0 ? (32'd1 << mi[j]) : 32'd0);
        chk({nm, " multi"},  32'(m),   32'(mm[j]));
    endtask

    task automatic check_all();
        chk_inst("fix", 0, fv, 8'(fi), 8'(fo), fm);
        chk_inst("rr4", 1, rv, 8'(ri), 8'(ro), rm);
        chk_inst("rr5", 2, qv, 8'(qi), 8'(qo), qm);
    endtask

    // One clock: the model advances with the DUT, then outputs are checked
    // just after the edge. Inputs get driven after this returns.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Reset is asserted between edges and checked before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b0; req4 = '0; req5 = '0;
        model_reset();
        #2 check_all();
        #20 rst_n = 1'b1;

        // Empty after reset.
        repeat (5) step();
        chk("empty onehot", 32'(fo), 32'd0);

        // Fixed single capture with two requesters, then back to idle.
        req4 = 4'b0110; rdy = 1'b1;
        step();
        chk("r031 idx", 32'(fi), 32'd2);
        chk("r031 onehot", 32'(fo), 32'b0100);
        chk("r031 multi", 32'(fm), 32'd1);
        req4 = 4'b0000;
        step();
        chk("r031 idle", 32'(fv), 32'd0);

        // Round-robin rotation with all requests held.
        do_reset();
        req4 = 4'b1111; rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int exp_seq[5] = '{3, 2, 1, 0, 3};
            step();
            chk("r032 idx", 32'(ri), 32'(exp_seq[k]));
            chk("r032 valid", 32'(rv), 32'd1);
        end

        // Hold without handshake, even when req changes.
        do_reset();
        req4 = 4'b0001; rdy = 1'b0;
        step();
        req4 = 4'b1000;
        repeat (3) begin
            step();
            chk("r033 hold idx", 32'(ri), 32'd0);
            chk("r033 hold valid", 32'(rv), 32'd1);
        end
        rdy = 1'b1;
        step();
        chk("r033 next idx", 32'(ri), 32'd3);

        // Wrap: 3 accepted -> ptr=2 -> 0 wins; 0 accepted -> ptr=3 -> 3 wins.
        req4 = 4'b1001;
        step();
        chk("r035 idx0", 32'(ri), 32'd0);
        step();
        chk("r035 idx3", 32'(ri), 32'd3);

        // Reset during a grant, then ptr must be back at N-1.
        rdy = 1'b0;
        do_reset();
        chk("r036 valid", 32'(rv), 32'd0);
        req4 = 4'b1111; rdy = 1'b1;
        step();
        chk("r036 ptr", 32'(ri), 32'd3);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            req4 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            req5 = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
